// File: rtl/hidden_ram_pkg.sv
// Shared constants and state encoding for the hidden RAM read engine.
package hidden_ram_pkg;
  localparam int HR_DATA_W = 128;
  localparam int HR_ADDR_W = 4;
  localparam int HR_PIX_W  = 8;
  localparam int HR_BEATS  = HR_DATA_W / HR_PIX_W;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } hr_rd_state_t;
endpackage

// File: rtl/hidden_ram_reader_serializer.sv
// Row serializer: holds one captured RAM row and hands it out one pixel at a
// time, least-significant pixel first.
module hr_row_serializer
  import hidden_ram_pkg::*;
#(
  parameter int DATA_W = HR_DATA_W,
  parameter int PIX_W  = HR_PIX_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shift,
  output logic [PIX_W-1:0]  o_pix,
  output logic              o_last
);
  localparam int BEATS  = DATA_W / PIX_W;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [DATA_W-1:0] shreg;
  logic [BCNT_W-1:0] beat_cnt;

  // Capture a row on load; on each accepted beat drop the bottom pixel.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shreg    <= '0;
      beat_cnt <= '0;
    end else if (i_load) begin
      shreg    <= i_data;
      beat_cnt <= '0;
    end else if (i_shift) begin
      shreg    <= shreg >> PIX_W;
      beat_cnt <= beat_cnt + BCNT_W'(1);
    end
  end

  assign o_pix  = shreg[PIX_W-1:0];
  assign o_last = (beat_cnt == BCNT_W'(BEATS - 1));
endmodule

// File: rtl/hidden_ram_reader.sv
// Read engine for the hidden RAM: fetches a run of consecutive rows and
// streams each one out as pixels, then pulses done.
module hidden_ram_reader
  import hidden_ram_pkg::*;
#(
  parameter int DATA_W = HR_DATA_W,
  parameter int ADDR_W = HR_ADDR_W,
  parameter int PIX_W  = HR_PIX_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_first_row,
  input  logic [ADDR_W:0]   i_num_rows,
  output logic [ADDR_W-1:0] o_addr_r,
  output logic              o_read,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [PIX_W-1:0]  o_pix_data,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic              o_busy,
  output logic              o_done
);
  localparam int ROWS = 2 ** ADDR_W;

  hr_rd_state_t      state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rows_left;
  logic [ADDR_W:0]   num_clamped;
  logic [PIX_W-1:0]  ser_pix;
  logic              ser_last;
  logic              xfer;
  logic              row_end;
  logic              accept;

  assign num_clamped = (i_num_rows > (ADDR_W+1)'(ROWS)) ? (ADDR_W+1)'(ROWS) : i_num_rows;
  // An abort in the same cycle voids the handshake, so the pixel is not consumed.
  assign xfer    = (state == SHIFT) && i_pix_ready && !i_abort;
  assign row_end = xfer && ser_last;
  assign accept  = (state == IDLE) && i_start && !i_abort;

  hr_row_serializer #(.DATA_W(DATA_W), .PIX_W(PIX_W)) u_ser (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_load   (state == FETCH),
    .i_data   (i_rdata),
    .i_shift  (xfer),
    .o_pix    (ser_pix),
    .o_last   (ser_last)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (i_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_start) state_nxt = (num_clamped == '0) ? DONE : FETCH;
        FETCH:   state_nxt = SHIFT;
        SHIFT:   if (row_end) state_nxt = (rows_left == (ADDR_W+1)'(1)) ? DONE : FETCH;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Row address and remaining-row counter: loaded on start, stepped per row.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr      <= '0;
      rows_left <= '0;
    end else if (accept && (num_clamped != '0)) begin
      addr      <= i_first_row;
      rows_left <= num_clamped;
    end else if (row_end) begin
      addr      <= addr + ADDR_W'(1);
      rows_left <= rows_left - (ADDR_W+1)'(1);
    end
  end

  // Outputs decode from state only (plus held registers), never from inputs.
  assign o_read      = (state == FETCH);
  assign o_addr_r    = o_read ? addr : '0;
  assign o_pix_valid = (state == SHIFT);
  assign o_pix_data  = o_pix_valid ? ser_pix : '0;
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);
endmodule

// File: doc/hidden_ram_reader.md
Name: hidden_ram_reader

Overview:
- Read-side engine for the 16 x 128-bit hidden RAM store.
- On a start pulse, it fetches a run of consecutive rows through the RAM's combinational read port. Each row is serialized into 8-bit pixels, least-significant byte first, on a valid/ready stream toward the GIF frame renderer.
- Sits between the hidden RAM and the pixel pipeline, and signals completion with a one-cycle done pulse.

Parameters:
- DATA_W, 128, RAM row width in bits.
- ADDR_W, 4, RAM address width (2**ADDR_W rows).
- PIX_W, 8, pixel width; DATA_W must be an integer multiple of PIX_W.

Ports:
- i_clk  input  1  system clock, all logic rising-edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle request to begin a run; honoured only in IDLE.
- i_abort  input  1  synchronous abort; returns to IDLE, no done pulse.
- i_first_row  input  ADDR_W  first row address of the run.
- i_num_rows  input  ADDR_W+1  rows in the run, 0..16; values above 16 are clamped to 16.
- o_addr_r  output  ADDR_W  RAM read address.
- o_read  output  1  RAM read enable.
- i_rdata  input  DATA_W  RAM read data, valid combinationally while o_read is high.
- o_pix_data  output  PIX_W  pixel data.
- o_pix_valid  output  1  pixel valid.
- i_pix_ready  input  1  downstream ready.
- o_busy  output  1  high from the cycle after an accepted start until back in IDLE.
- o_done  output  1  one-cycle pulse after the final pixel of a run is accepted.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - state = IDLE, all registers cleared.
  - o_read, o_pix_valid, o_busy, o_done = 0; o_addr_r = 0; o_pix_data = 0.
- BEATS = DATA_W/PIX_W (16 by default).
- Registers: addr (ADDR_W), rows_left (ADDR_W+1), beat_cnt (log2 BEATS), shreg (DATA_W).
- IDLE:
  - i_start with clamped count N > 0: addr <= i_first_row, rows_left <= N, go to FETCH.
  - i_start with N == 0: go to DONE. No RAM access and no pixels.
- FETCH (exactly 1 cycle):
  - o_read = 1, o_addr_r = addr.
  - At the clock edge: shreg <= i_rdata, beat_cnt <= 0, go to SHIFT.
- SHIFT:
  - o_pix_valid = 1, o_pix_data = shreg[PIX_W-1:0].
  - Data and valid hold steady while i_pix_ready = 0.
  - On valid && ready: shreg shifts right by PIX_W and beat_cnt increments.
  - On the handshake where beat_cnt == BEATS-1: addr <= addr+1 (wraps 15 -> 0), rows_left decrements.
    - If rows_left was 1: go to DONE.
    - Otherwise: go to FETCH.
- DONE: o_done = 1 for one cycle, then IDLE.
- Timing:
  - Start accepted at edge k: o_read high in cycle k+1, first o_pix_valid in cycle k+2.
  - Each row costs 1 fetch bubble plus 16 beats; with ready held high, one row takes 17 cycles.
- Output decode:
  - o_read and o_addr_r are decoded from the state register only; no input feeds them combinationally.
  - o_addr_r = 0 outside FETCH.
  - o_pix_data comes from shreg, gated to 0 when not in SHIFT.
- Boundary cases:
  - i_start outside IDLE is ignored.
  - i_abort has priority over all transitions: go to IDLE next edge, o_done stays 0, and any pixel shown that cycle counts as not transferred.
  - i_first_row and i_num_rows are sampled only on start acceptance; later changes have no effect.
  - A RAM write during a run is not coordinated. A row already captured in shreg is unaffected; later rows return whatever the RAM holds at their FETCH cycle.

Decomposition:
- Package hidden_ram_pkg:
  - constants HR_DATA_W = 128, HR_ADDR_W = 4, HR_PIX_W = 8, HR_BEATS = 16.
  - enum typedef hr_rd_state_t {IDLE, FETCH, SHIFT, DONE}.
- One sub-module, hr_row_serializer:
  - contains shreg and beat_cnt, with load, shift and last-beat outputs.
  - the FSM and row/address counters stay in hidden_ram_reader.

Test Plan:
- Single row: RAM row 3 = 0x0F0E..0100. Start with first_row = 3, num = 1, ready held 1.
  - Required: o_read with addr 3 in cycle k+1.
  - Pixels 0x00, 0x01 .. 0x0F on 16 consecutive cycles.
  - o_done in cycle k+18; o_busy low afterward.
- Wrap: first_row = 14, num = 3.
  - Required: fetch addresses 14, 15, 0 in order; 48 pixels; one done pulse.
- Backpressure: ready pattern 1,0,0,1 repeating over one row.
  - Required: o_pix_data stable during ready = 0; exactly 16 transfers in order.
- Zero and clamp cases:
  - num = 0: done pulse 1 cycle after start, o_read never asserted.
  - num = 17: exactly 16 rows fetched.
- Abort and restart: abort during beat 5 of row 2.
  - Required: IDLE next cycle, no done pulse.
  - A new start with first_row = 0, num = 1 then completes normally.
- Reset mid-run: deassert i_reset_n during SHIFT.
  - Required: all outputs 0 immediately (asynchronous).
  - After release, no activity until the next i_start.
